// File: rtl/gate_equiv_checker.sv
// Exhaustive-vector equivalence checker: steps vec_out through every input combination,
// compares ref_in against dut_in once per vector and reports mismatch count and first failure.
module gate_equiv_checker #(
   parameter int unsigned N_IN    = 3,
   parameter int unsigned DWELL_W = 8,
   parameter int unsigned ERR_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N_IN-1:0]    vec_out,
   input  logic               ref_in,
   input  logic               dut_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_count,
   output logic [N_IN-1:0]    first_err_vec,
   output logic               first_err_valid
);

   typedef enum logic [1:0] {StIdle, StApply, StFin} state_t;

   state_t             state;
   logic [DWELL_W-1:0] dwell_lat;
   logic [DWELL_W-1:0] cnt;
   logic               mismatch;
   logic [ERR_W-1:0]   err_next;

   // Only the last cycle of each vector's dwell is a sample point.
   always_comb begin
      mismatch = (state == StApply) && (cnt == '0) && (ref_in != dut_in);
      err_next = err_count;
      if (mismatch && (err_count != {ERR_W{1'b1}})) begin
         err_next = err_count + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= StIdle;
         vec_out         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
         dwell_lat       <= '0;
         cnt             <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  state           <= StApply;
                  busy            <= 1'b1;
                  vec_out         <= '0;
                  cnt             <= dwell;
                  dwell_lat       <= dwell;
                  err_count       <= '0;
                  pass            <= 1'b0;
                  first_err_vec   <= '0;
                  first_err_valid <= 1'b0;
               end
            end
            StApply: begin
               err_count <= err_next;
               if (cnt != '0) begin
                  cnt <= cnt - DWELL_W'(1);
               end else begin
                  if (mismatch && !first_err_valid) begin
                     first_err_vec   <= vec_out;
                     first_err_valid <= 1'b1;
                  end
                  if (vec_out != {N_IN{1'b1}}) begin
                     vec_out <= vec_out + N_IN'(1);
                     cnt     <= dwell_lat;
                  end else begin
                     // pass uses err_next so the final sample is included.
                     state <= StFin;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0);
                  end
               end
            end
            StFin: begin
               done    <= 1'b0;
               state   <= StIdle;
               vec_out <= '0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_equiv_checker.sv
// Randomized self-checking bench for gate_equiv_checker; a second instance with a 2-bit
// error counter exercises saturation alongside every run.
module tb_gate_equiv_checker;

   localparam int unsigned N_IN = 3;
   localparam int unsigned NVEC = 1 << N_IN;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [7:0]      dwell;
   logic            ref_in, dut_in, sat_ref, sat_dut;
   logic [N_IN-1:0] vec_out, sat_vec;
   logic            busy, done, pass, fev_valid;
   logic            sat_busy, sat_done, sat_pass, sat_fev_valid;
   logic [7:0]      err_count;
   logic [1:0]      sat_err;
   logic [N_IN-1:0] fev, sat_fev;

   int checks   = 0;
   int failures = 0;

   gate_equiv_checker #(.N_IN(N_IN), .DWELL_W(8), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dwell(dwell), .vec_out(vec_out),
      .ref_in(ref_in), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_vec(fev), .first_err_valid(fev_valid)
   );

   gate_equiv_checker #(.N_IN(N_IN), .DWELL_W(8), .ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .dwell(dwell), .vec_out(sat_vec),
      .ref_in(sat_ref), .dut_in(sat_dut), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
      .err_count(sat_err), .first_err_vec(sat_fev), .first_err_valid(sat_fev_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err"}, 32'(err_count), 32'd0);
      check({tag, "_vec"}, 32'(vec_out), 32'd0);
      check({tag, "_fev"}, 32'(fev), 32'd0);
      check({tag, "_fevv"}, 32'(fev_valid), 32'd0);
      check({tag, "_sat_err"}, 32'(sat_err), 32'd0);
   endtask

   // mode: 0 clean, 1 mismatch on vector 5, 2 random mismatches, 3 glitches off sample points
   task automatic do_run(input int d, input int mode, input bit spam);
      int total, errs, samples, first_vec, exp_err;
      bit mism, sample, f;
      logic [N_IN-1:0] v;
      total = NVEC * (d + 1);
      errs = 0;
      samples = 0;
      first_vec = -1;
      dwell = 8'(d);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < total; i++) begin
         v = N_IN'(i / (d + 1));
         sample = (i % (d + 1)) == d;
         check("busy_run", 32'(busy), 32'd1);
         check("vec_run", 32'(vec_out), 32'(v));
         check("done_run", 32'(done), 32'd0);
         if (spam) begin
            start = 1'($urandom_range(0, 1));
            dwell = 8'($urandom);
         end
         case (mode)
            0:       mism = 1'b0;
            1:       mism = (v == 3'd5);
            2:       mism = ($urandom_range(0, 3) == 0);
            default: mism = !sample && ($urandom_range(0, 1) == 1);
         endcase
         f = (v[0] & v[1]) | v[2];
         ref_in  = f;
         dut_in  = f ^ mism;
         sat_ref = f;
         sat_dut = ~f;
         if (sample) samples++;
         if (sample && mism) begin
            errs++;
            if (first_vec < 0) first_vec = int'(v);
         end
         @(posedge clk); #1;
      end
      exp_err = (errs > 255) ? 255 : errs;
      check("fin_done", 32'(done), 32'd1);
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_vec", 32'(vec_out), NVEC - 1);
      check("fin_err", 32'(err_count), 32'(exp_err));
      check("fin_pass", 32'(pass), 32'(errs == 0));
      check("fin_fevv", 32'(fev_valid), 32'(first_vec >= 0));
      check("fin_fev", 32'(fev), (first_vec >= 0) ? 32'(first_vec) : 32'd0);
      check("sat_done", 32'(sat_done), 32'd1);
      check("sat_err", 32'(sat_err), (samples > 3) ? 32'd3 : 32'(samples));
      check("sat_pass", 32'(sat_pass), 32'd0);
      check("sat_fev", 32'(sat_fev), 32'd0);
      if (spam) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_done", 32'(done), 32'd0);
      check("idle_vec", 32'(vec_out), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("hold_pass", 32'(pass), 32'(errs == 0));
      check("hold_err", 32'(err_count), 32'(exp_err));
      check("hold_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      dwell = 8'd0;
      ref_in = 1'b0;
      dut_in = 1'b0;
      sat_ref = 1'b0;
      sat_dut = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst0");
      rst = 1'b0;
      @(posedge clk); #1;

      do_run(0, 0, 1'b0);
      do_run(0, 1, 1'b0);
      do_run(3, 3, 1'b0);
      do_run(3, 2, 1'b0);
      do_run(2, 1, 1'b1);
      do_run(1, 0, 1'b0);
      for (int k = 0; k < 3; k++) do_run(int'($urandom_range(0, 5)), 2, 1'b1);

      // Mid-run reset with two mismatches already counted.
      dwell = 8'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ref_in = 1'b0;
         dut_in = (i == 1 || i == 2);
         @(posedge clk); #1;
      end
      check("pre_rst_vec", 32'(vec_out), 32'd4);
      check("pre_rst_err", 32'(err_count), 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      dut_in = 1'b0;
      check_reset_state("rst_mid");
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
